// File: rtl/demux_rr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : demux_rr_ctrl
// Purpose  : Flow-controlled 1:2 demultiplexer controller. A single
//            valid/ready input stream is steered onto two one-beat output
//            buffers (y0, y1). Steering is either round-robin in bursts of
//            BURST beats (mode=0) or fixed by sel_in (mode=1).
// Ports    : clk, rst_n            - clock, async active-low reset
//            mode, sel_in          - routing mode / fixed target channel
//            x_valid/x_ready/x_data- input stream
//            yK_valid/yK_ready/yK_data - output channels (K = 0, 1)
//            s                     - registered current target channel
//            burst_cnt             - beats accepted in the current burst
//            beats0/beats1         - wrapping per-channel accept counters
// Revision : 1.0 - initial release
// ============================================================================
module demux_rr_ctrl #(
    parameter int WIDTH = 8,
    parameter int BURST = 4     // legal range 1..255
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mode,
    input  logic             sel_in,
    input  logic             x_valid,
    input  logic [WIDTH-1:0] x_data,
    output logic             x_ready,
    output logic             y0_valid,
    output logic [WIDTH-1:0] y0_data,
    input  logic             y0_ready,
    output logic             y1_valid,
    output logic [WIDTH-1:0] y1_data,
    input  logic             y1_ready,
    output logic             s,
    output logic [7:0]       burst_cnt,
    output logic [15:0]      beats0,
    output logic [15:0]      beats1
);

    localparam logic [7:0] c_burst_last = 8'(BURST - 1);

    typedef enum logic [0:0] {
        ST_CH0 = 1'b0,
        ST_CH1 = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [7:0]       r_burst_cnt;
    logic [7:0]       w_burst_cnt_nxt;

    logic [1:0]       r_valid;
    logic [WIDTH-1:0] r_data  [2];
    logic [15:0]      r_beats [2];

    logic             w_t;
    logic             w_accept;
    logic [1:0]       w_load;
    logic [1:0]       w_ready;

    // Effective target: sel_in wins immediately in fixed mode, so a mode or
    // select change steers the very beat offered in that cycle.
    assign w_t      = mode ? sel_in : (r_state == ST_CH1);
    assign w_ready  = {y1_ready, y0_ready};

    // Strict routing: only the target's buffer state matters. A full buffer
    // that is being drained this cycle can be refilled in the same cycle.
    assign x_ready  = w_t ? (!r_valid[1] || y1_ready) : (!r_valid[0] || y0_ready);
    assign w_accept = x_valid && x_ready;
    assign w_load   = {w_accept && w_t, w_accept && !w_t};

    // ------------------------------------------------------------------
    // Routing state machine
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_CH0;
            r_burst_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_burst_cnt_nxt = r_burst_cnt;
        if (mode) begin
            // Fixed mode tracks sel_in and discards any partial burst, so a
            // later return to round-robin starts a fresh burst from s.
            w_state_nxt     = sel_in ? ST_CH1 : ST_CH0;
            w_burst_cnt_nxt = '0;
        end else if (w_accept) begin
            if (r_burst_cnt >= c_burst_last) begin
                w_burst_cnt_nxt = '0;
                unique case (r_state)
                    ST_CH0:  w_state_nxt = ST_CH1;
                    ST_CH1:  w_state_nxt = ST_CH0;
                    default: w_state_nxt = ST_CH0;
                endcase
            end else begin
                w_burst_cnt_nxt = r_burst_cnt + 8'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Per-channel one-beat buffers and beat counters
    // ------------------------------------------------------------------
    generate
        for (genvar k = 0; k < 2; k++) begin : g_ch
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_valid[k] <= 1'b0;
                    r_data[k]  <= '0;
                    r_beats[k] <= '0;
                end else begin
                    if (w_load[k]) begin
                        r_valid[k] <= 1'b1;
                        r_data[k]  <= x_data;
                        r_beats[k] <= r_beats[k] + 16'd1;
                    end else if (r_valid[k] && w_ready[k]) begin
                        // Data is left as-is after a drain; only valid drops.
                        r_valid[k] <= 1'b0;
                    end
                end
            end
        end
    endgenerate

    assign y0_valid  = r_valid[0];
    assign y1_valid  = r_valid[1];
    assign y0_data   = r_data[0];
    assign y1_data   = r_data[1];
    assign beats0    = r_beats[0];
    assign beats1    = r_beats[1];
    assign s         = (r_state == ST_CH1);
    assign burst_cnt = r_burst_cnt;

endmodule
`default_nettype wire

// File: tb/tb_demux_rr_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_demux_rr_ctrl
// Purpose  : Self-checking bench for demux_rr_ctrl. A driver issues beats and
//            predicts routing with a behavioural model; expected beats are
//            queued per channel and a separate monitor pops and compares
//            whenever an output handshake happens.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demux_rr_ctrl;

    localparam int WIDTH = 8;
    localparam int BURST = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             mode;
    logic             sel_in;
    logic             x_valid;
    logic [WIDTH-1:0] x_data;
    logic             x_ready;
    logic             y0_valid;
    logic [WIDTH-1:0] y0_data;
    logic             y0_ready;
    logic             y1_valid;
    logic [WIDTH-1:0] y1_data;
    logic             y1_ready;
    logic             s;
    logic [7:0]       burst_cnt;
    logic [15:0]      beats0;
    logic [15:0]      beats1;

    demux_rr_ctrl #(.WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .sel_in    (sel_in),
        .x_valid   (x_valid),
        .x_data    (x_data),
        .x_ready   (x_ready),
        .y0_valid  (y0_valid),
        .y0_data   (y0_data),
        .y0_ready  (y0_ready),
        .y1_valid  (y1_valid),
        .y1_data   (y1_data),
        .y1_ready  (y1_ready),
        .s         (s),
        .burst_cnt (burst_cnt),
        .beats0    (beats0),
        .beats1    (beats1)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Scoreboard: beats expected on each channel, in order.
    logic [WIDTH-1:0] q0[$];
    logic [WIDTH-1:0] q1[$];

    // Behavioural model: target channel, beats in current burst,
    // per-channel occupancy and accept counts.
    int m_s;
    int m_cnt;
    int m_beats [2];
    bit m_full  [2];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        m_s = 0;
        m_cnt = 0;
        m_beats[0] = 0;
        m_beats[1] = 0;
        m_full[0] = 1'b0;
        m_full[1] = 1'b0;
        q0.delete();
        q1.delete();
    endtask

    task automatic check_state();
        chk("s",         32'(s),         32'(m_s));
        chk("burst_cnt", 32'(burst_cnt), 32'(m_cnt));
        chk("beats0",    32'(beats0),    32'(m_beats[0]));
        chk("beats1",    32'(beats1),    32'(m_beats[1]));
        chk("y0_valid",  32'(y0_valid),  32'(m_full[0]));
        chk("y1_valid",  32'(y1_valid),  32'(m_full[1]));
    endtask

    // One clock cycle: check registered state, drive new inputs, check the
    // combinational x_ready, then advance the model across the coming edge.
    task automatic step(input bit xv, input logic [WIDTH-1:0] xd, input bit md,
                        input bit sl, input bit r0, input bit r1);
        int t;
        bit rdy;
        bit acc;
        @(posedge clk);
        #1;
        check_state();
        x_valid  = xv;
        x_data   = xd;
        mode     = md;
        sel_in   = sl;
        y0_ready = r0;
        y1_ready = r1;
        #1;
        t   = md ? int'(sl) : m_s;
        rdy = (t == 1) ? (!m_full[1] || r1) : (!m_full[0] || r0);
        chk("x_ready", 32'(x_ready), 32'(rdy));
        acc = xv && rdy;
        if (m_full[0] && r0) m_full[0] = 1'b0;
        if (m_full[1] && r1) m_full[1] = 1'b0;
        if (acc) begin
            m_full[t] = 1'b1;
            if (t == 1) q1.push_back(xd);
            else        q0.push_back(xd);
            m_beats[t] = (m_beats[t] + 1) % 65536;
        end
        if (md) begin
            m_s   = int'(sl);
            m_cnt = 0;
        end else if (acc) begin
            m_cnt++;
            if (m_cnt == BURST) begin
                m_cnt = 0;
                m_s   = 1 - m_s;
            end
        end
    endtask

    task automatic idle(input bit md, input bit sl);
        step(1'b0, '0, md, sl, 1'b1, 1'b1);
    endtask

    task automatic do_reset();
        x_valid  = 1'b0;
        x_data   = '0;
        mode     = 1'b0;
        sel_in   = 1'b0;
        y0_ready = 1'b0;
        y1_ready = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("rst_y0_valid", 32'(y0_valid),  32'd0);
        chk("rst_y1_valid", 32'(y1_valid),  32'd0);
        chk("rst_y0_data",  32'(y0_data),   32'd0);
        chk("rst_y1_data",  32'(y1_data),   32'd0);
        chk("rst_s",        32'(s),         32'd0);
        chk("rst_burst",    32'(burst_cnt), 32'd0);
        chk("rst_beats0",   32'(beats0),    32'd0);
        chk("rst_beats1",   32'(beats1),    32'd0);
        chk("rst_x_ready",  32'(x_ready),   32'd1);
        model_clear();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
    endtask

    // Output monitor: compares every delivered beat with the scoreboard and
    // checks that a stalled beat keeps valid high and data stable.
    task automatic monitor();
        bit               st [2];
        logic [WIDTH-1:0] pd [2];
        st[0] = 1'b0;
        st[1] = 1'b0;
        forever begin
            @(negedge clk);
            if (rst_n !== 1'b1) begin
                st[0] = 1'b0;
                st[1] = 1'b0;
                continue;
            end
            if (st[0]) begin
                chk("y0_hold_valid", 32'(y0_valid), 32'd1);
                chk("y0_hold_data",  32'(y0_data),  32'(pd[0]));
            end
            if (y0_valid && y0_ready) begin
                if (q0.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL y0_extra_beat: got 0x%0h expected no beat at %0t", y0_data, $time);
                end else begin
                    chk("y0_data", 32'(y0_data), 32'(q0.pop_front()));
                end
            end
            st[0] = y0_valid && !y0_ready;
            pd[0] = y0_data;

            if (st[1]) begin
                chk("y1_hold_valid", 32'(y1_valid), 32'd1);
                chk("y1_hold_data",  32'(y1_data),  32'(pd[1]));
            end
            if (y1_valid && y1_ready) begin
                if (q1.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL y1_extra_beat: got 0x%0h expected no beat at %0t", y1_data, $time);
                end else begin
                    chk("y1_data", 32'(y1_data), 32'(q1.pop_front()));
                end
            end
            st[1] = y1_valid && !y1_ready;
            pd[1] = y1_data;
        end
    endtask

    initial begin
        bit cur_md;
        fork
            monitor();
        join_none

        do_reset();
        idle(1'b0, 1'b0);

        // Round-robin: 0x01..0x10 back-to-back, both readies high.
        for (int i = 1; i <= 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1'b0, 1'b0);
        chk("rr_beats0", 32'(beats0), 32'd8);
        chk("rr_beats1", 32'(beats1), 32'd8);
        chk("rr_s",      32'(s),      32'd0);

        // Backpressure on y1.
        for (int i = 0; i < 4; i++) step(1'b1, 8'h40 + 8'(i), 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 1'b0);
            chk("bp_y1_data",  32'(y1_data), 32'h55);
            chk("bp_x_ready",  32'(x_ready), 32'd0);
            chk("bp_beats0",   32'(beats0),  32'd12);
        end
        step(1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1'b0, 1'b0);
        chk("bp_beats1_end", 32'(beats1), 32'd10);
        chk("bp_beats0_end", 32'(beats0), 32'd12);

        // Fixed mode: sel 1,1,0,1 with beats A,B,C,D.
        step(1'b1, 8'hA0, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 8'hB0, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b1, 8'hC0, 1'b1, 1'b0, 1'b1, 1'b1);
        step(1'b1, 8'hD0, 1'b1, 1'b1, 1'b1, 1'b1);
        idle(1'b1, 1'b1);
        chk("fx_burst_cnt", 32'(burst_cnt), 32'd0);
        chk("fx_beats0",    32'(beats0),    32'd13);
        chk("fx_beats1",    32'(beats1),    32'd13);

        // Mode switch mid-burst.
        idle(1'b1, 1'b0);
        step(1'b1, 8'h21, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b1, 1'b1);
        step(1'b1, 8'h23, 1'b1, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(1'b1, 8'h24 + 8'(i), 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1'b0, 1'b0);
        chk("ms_s",         32'(s),         32'd1);
        chk("ms_burst_cnt", 32'(burst_cnt), 32'd0);
        chk("ms_beats0",    32'(beats0),    32'd20);

        // Randomized traffic.
        cur_md = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) cur_md = ~cur_md;
            step(($urandom % 4) != 0, 8'($urandom), cur_md, 1'($urandom),
                 ($urandom % 4) != 0, ($urandom % 4) != 0);
        end

        // Reset with both buffers full.
        step(1'b1, 8'hE0, 1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hE1, 1'b1, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #2;
        chk("pre_rst_y0_valid", 32'(y0_valid), 32'd1);
        chk("pre_rst_y1_valid", 32'(y1_valid), 32'd1);
        do_reset();
        step(1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(1'b0, 1'b0);
        chk("post_rst_y0_data", 32'(y0_data), 32'h77);
        chk("post_rst_y1_valid", 32'(y1_valid), 32'd0);

        // Counter wrap: 65536 accepts into y0.
        do_reset();
        for (int i = 0; i < 65536; i++) step(1'b1, 8'(i), 1'b1, 1'b0, 1'b1, 1'b1);
        idle(1'b1, 1'b0);
        chk("wrap_beats0", 32'(beats0), 32'd0);
        chk("wrap_beats1", 32'(beats1), 32'd0);

        idle(1'b0, 1'b0);
        idle(1'b0, 1'b0);
        chk("q0_leftover", 32'(q0.size()), 32'd0);
        chk("q1_leftover", 32'(q1.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/demux_rr_ctrl.md
# demux_rr_ctrl

Flow-controlled 1:2 demultiplexer controller that routes a single valid/ready input stream onto two buffered output channels, y0 and y1. Routing is either round-robin in fixed-length bursts or software-steered by a select input. It generates the `s` select sequence that drives the 1:2 demux datapath, holds one registered beat per output, and counts beats delivered per channel.

## Interface
- `WIDTH`, default 8: data width of the input and of each output channel.
- `BURST`, default 4: beats routed to one channel before round-robin switches; legal range 1..255.
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `mode`  input  1: 0 = round-robin bursts, 1 = fixed select from `sel_in`.
- `sel_in`  input  1: target channel when `mode`=1 (0 → y0, 1 → y1).
- `x_valid`  input  1: input beat present.
- `x_data`  input  WIDTH: input beat.
- `x_ready`  output  1: input beat accepted this cycle when `x_valid` and `x_ready` are both high.
- `y0_valid` / `y1_valid`  output  1: channel buffer holds a beat.
- `y0_data` / `y1_data`  output  WIDTH: channel buffer contents.
- `y0_ready` / `y1_ready`  input  1: downstream takes the beat when valid and ready are both high.
- `s`  output  1: current target channel (registered).
- `burst_cnt`  output  8: beats accepted in the current burst.
- `beats0` / `beats1`  output  16: wrapping count of beats accepted for y0 / y1.

## Operation
- Effective target `t` = `sel_in` when `mode`=1, otherwise `s`.
- Accept condition: `x_ready` = !y`t`_valid | y`t`_ready. It is combinational from the ready inputs and the registered valid; it does not depend on `x_valid`. Routing is strict: the block never skips to the other channel while the target is blocked.
- On accept:
  - y`t`_data ← `x_data`, y`t`_valid ← 1.
  - beats`t` increments by 1, wrapping 0xFFFF → 0.
- On drain (valid & ready) with no new accept into that channel: that channel's valid ← 0; data holds its last value.
- Channels are independent. The non-target channel can drain in the same cycle as an accept into the target.
- State machine, `mode`=0, states CH0 (`s`=0) and CH1 (`s`=1):
  - Each accept increments `burst_cnt`.
  - The accept that brings `burst_cnt` to `BURST` sets `burst_cnt` ← 0 and toggles `s`. The next beat goes to the other channel.
  - No transition occurs without an accept.
- `mode`=1:
  - `s` ← `sel_in` every cycle.
  - `burst_cnt` is held at 0.
- Mode change 1 → 0: round-robin resumes from the current `s` with `burst_cnt`=0.
- Mode change 0 → 1 mid-burst: partial count discarded, `burst_cnt` ← 0. Takes effect on the same cycle's target, because `t` is combinational from `mode` and `sel_in`.
- `BURST`=1: `s` alternates on every accept.

## Timing
- Reset (asynchronous assert, synchronous-to-`clk` release):
  - `s`=0, `burst_cnt`=0, `beats0`=`beats1`=0.
  - `y0_valid`=`y1_valid`=0, `y0_data`=`y1_data`=0.
  - `x_ready`=1 follows from the empty buffers.
- Reset mid-operation: buffered beats are discarded and not delivered; counters are cleared.
- Latency: a beat accepted at edge N is visible on y`t` from just after edge N.
- Throughput: 1 beat/cycle sustained while the target's ready stays high. This includes a full buffer draining and refilling in the same cycle.
- Handshake rules:
  - y`k`_valid, once high, stays high with data stable until y`k`_ready is sampled high.
  - A beat offered while `x_ready`=0 is not consumed and is not counted.
- `burst_cnt`, `s` and beat counters change only on clock edges. No combinational path from `x_valid` to any output.

## Test plan
- Reset check: assert `rst_n`=0 mid-stream with both buffers full → same cycle all outputs zero, `x_ready`=1. After release, first beat goes to y0.
- Round-robin, `BURST`=4, `mode`=0, both readies high, send 0x01..0x10 back-to-back:
  - y0 gets 01–04 and 09–0C; y1 gets 05–08 and 0D–10.
  - One beat per cycle; `beats0`=`beats1`=8 at end.
- Backpressure: hold `y1_ready`=0 while `s`=1.
  - First beat to y1 is accepted, then `x_ready`=0. `x_valid` stays asserted with the same data; y0 receives nothing.
  - Raise `y1_ready` → stalled beat accepted that cycle; `y1_data` is held stable throughout the stall.
- Fixed mode: `mode`=1, `sel_in` pattern 1,1,0,1 with beats A,B,C,D → y1 gets A,B,D and y0 gets C; `burst_cnt` stays 0.
- Mode switch mid-burst: `mode`=0 after 2 of 4 beats on y0, switch to `mode`=1 with `sel_in`=0 for 1 beat, then back to `mode`=0 → the next 4 beats all go to y0 (`burst_cnt` restarts at 0), then `s` toggles to 1.
- Counter wrap: force 65536 accepts into y0 → `beats0` returns to 0; `beats1` unchanged.
